scoreboard_regfile: RTL and testbench
=====================================

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning register count (power of two, >=2); AW = $clog2(DEPTH).
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports.
REQ-004 SHALL have parameter NWR, default 2, meaning number of write ports.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, the reset: asynchronous and active-low.
REQ-007 SHALL have port we, input, [NWR], meaning per-port write enable.
REQ-008 SHALL have port waddr, input, [NWR][AW], meaning per-port write index.
REQ-009 SHALL have port wdata, input, [NWR][WIDTH], meaning per-port write data.
REQ-010 SHALL have port raddr, input, [NRD][AW], meaning per-port read index.
REQ-011 SHALL have port rdata, output, [NRD][WIDTH], meaning per-port read data.
REQ-012 SHALL have port rbusy, output, [NRD], meaning the read register has an outstanding producer.
REQ-013 SHALL have port issue_valid, input, 1, meaning mark issue_rd busy.
REQ-014 SHALL have port issue_rd, input, [AW], meaning the destination index being issued.
REQ-015 SHALL have port busy_count, output, [AW+1], meaning the number of busy registers.

Function
REQ-016 Register 0 SHALL read as 0, ignore writes and never become busy.
REQ-017 Writes SHALL be synchronous: when we[i] is high and waddr[i] is not 0, the register is updated at the next edge.
REQ-018 When several write ports target the same index in one cycle, the highest-numbered port SHALL win.
REQ-019 Reads SHALL be combinational: rdata[j] is the stored value of raddr[j].
REQ-020 rbusy[j] SHALL be combinational: busy[raddr[j]].
REQ-021 issue_valid with issue_rd not 0 SHALL set busy[issue_rd] at the next edge.
REQ-022 A write to index k SHALL clear busy[k] at the next edge.
REQ-023 When an issue and a write target the same index in the same cycle, the issue SHALL win: the data is written and busy stays 1.
REQ-024 Issuing to an already-busy register SHALL leave it busy, with no count change.
REQ-025 busy_count SHALL be a registered counter of busy bits.
REQ-026 busy_count SHALL change each cycle by +1 per newly set bit and -1 per newly cleared bit, with duplicate writes counted once.
REQ-027 busy_count SHALL never exceed DEPTH-1 and never go below 0.

Reset
REQ-028 While rst is low, all registers SHALL be 0, all busy bits 0 and busy_count 0, immediately and independent of clk.
REQ-029 Writes and issues in flight when reset asserts SHALL be discarded.
REQ-030 rdata and rbusy SHALL reflect the cleared state during reset.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN defined: if any we[i] matches raddr[j] (not 0) in the same cycle, rdata[j] SHALL return that port's wdata (highest port wins) and rbusy[j] SHALL read 0 unless issue_valid targets the same index.
REQ-032 Macro REGFILE_BYPASS_EN undefined: reads SHALL return the pre-edge stored value and busy bit with no forwarding.

Structure
REQ-033 rv32i_types SHALL hold rv32i_word and a reg-index typedef for the WIDTH=32 / DEPTH=32 instance; the module itself stays parameter-generic.
REQ-034 The module SHALL have one sub-module, regfile_bypass_mux, for the per-read-port priority select over NWR write ports; it is instantiated NRD times.

Verification
REQ-035 Reset release; write x5=0xDEADBEEF via port 0 -> next cycle raddr[0]=5 gives 0xDEADBEEF; raddr[1]=0 gives 0.
REQ-036 Ports 0 and 1 both write x7 (0x11, 0x22) -> x7=0x22; writes to x0 -> x0 reads 0.
REQ-037 issue x3 -> rbusy=1 and busy_count=1; a later write to x3 -> rbusy=0 and busy_count=0.
REQ-038 Same cycle: issue x4 and write x4=0x55 -> x4=0x55, busy stays 1, busy_count +1.
REQ-039 With REGFILE_BYPASS_EN: write x9=0xA5 while reading x9 -> rdata=0xA5 the same cycle; without the macro, the old value is returned.
REQ-040 Issue x1..x31 in turn -> busy_count=31; assert rst mid-clock -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/scoreboard_regfile_pkg.sv
// Shared types and default parameters for the scoreboarded register file.
// rv32i_types carries the RV32I-sized word and register index.
package rv32i_types;
    typedef logic [31:0] rv32i_word;
    typedef logic [4:0]  rv32i_reg_idx;
endpackage

package scoreboard_regfile_pkg;
    import rv32i_types::*;

    localparam int DEF_WIDTH = $bits(rv32i_word);
    localparam int DEF_DEPTH = 2 ** $bits(rv32i_reg_idx);
    localparam int DEF_NRD   = 2;
    localparam int DEF_NWR   = 2;
endpackage

// File: rtl/scoreboard_regfile_if.sv
// Bundle of write, read, issue and status signals for scoreboard_regfile.
// The master drives writes/reads/issues; the slave is the register file.
interface scoreboard_regfile_if
    import scoreboard_regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NRD   = DEF_NRD,
    parameter int NWR   = DEF_NWR
);
    localparam int AW = $clog2(DEPTH);

    logic [NWR-1:0]            we;
    logic [NWR-1:0][AW-1:0]    waddr;
    logic [NWR-1:0][WIDTH-1:0] wdata;
    logic [NRD-1:0][AW-1:0]    raddr;
    logic [NRD-1:0][WIDTH-1:0] rdata;
    logic [NRD-1:0]            rbusy;
    logic                      issue_valid;
    logic [AW-1:0]             issue_rd;
    logic [AW:0]               busy_count;

    modport master (
        output we, waddr, wdata, raddr, issue_valid, issue_rd,
        input  rdata, rbusy, busy_count
    );

    modport slave (
        input  we, waddr, wdata, raddr, issue_valid, issue_rd,
        output rdata, rbusy, busy_count
    );
endinterface

// File: rtl/scoreboard_regfile_bypass_mux.sv
// Priority select over the write ports for one read port: the
// highest-numbered matching port supplies the forwarded data.
module regfile_bypass_mux #(
    parameter int WIDTH = 32,
    parameter int NWR   = 2
) (
    input  logic [NWR-1:0]            i_match,
    input  logic [NWR-1:0][WIDTH-1:0] i_wdata,
    output logic                      o_hit,
    output logic [WIDTH-1:0]          o_data
);
    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int i = 0; i < NWR; i++) begin
            if (i_match[i]) begin
                o_hit  = 1'b1;
                o_data = i_wdata[i];
            end
        end
    end
endmodule

// File: rtl/scoreboard_regfile.sv
// Multi-port register file with a per-register busy scoreboard and counter.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module scoreboard_regfile
    import scoreboard_regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NRD   = DEF_NRD,
    parameter int NWR   = DEF_NWR
) (
    input  logic               clk,
    input  logic               rst,
    scoreboard_regfile_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;
    logic [AW:0]      r_busy_count;
    logic [AW:0]      w_count_next;

    // NOTE: the array is reset because reads must show zeros while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) r_regs[k] <= '0;
        end else begin
            // NOTE: later non-blocking updates to the same entry override earlier ones, so the top port wins.
            for (int i = 0; i < NWR; i++) begin
                if (bus.we[i] && bus.waddr[i] != '0) r_regs[bus.waddr[i]] <= bus.wdata[i];
            end
        end
    end

    // Writes retire producers first; an issue to the same index re-marks it busy.
    always_comb begin
        w_busy_next = r_busy;
        for (int i = 0; i < NWR; i++) begin
            if (bus.we[i] && bus.waddr[i] != '0) w_busy_next[bus.waddr[i]] = 1'b0;
        end
        if (bus.issue_valid && bus.issue_rd != '0) w_busy_next[bus.issue_rd] = 1'b1;
    end

    always_comb begin
        w_count_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_count_next = w_count_next + (AW+1)'(w_busy_next[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_next;
            r_busy_count <= w_count_next;
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [NWR-1:0]   w_match;
        logic             w_hit;
        logic [WIDTH-1:0] w_fwd;

        always_comb begin
            w_match = '0;
`ifdef REGFILE_BYPASS_EN
            for (int i = 0; i < NWR; i++) begin
                w_match[i] = bus.we[i] && (bus.waddr[i] == bus.raddr[j]) && (bus.raddr[j] != '0);
            end
`endif
        end

        regfile_bypass_mux #(
            .WIDTH (WIDTH),
            .NWR   (NWR)
        ) u_bypass_mux (
            .i_match (w_match),
            .i_wdata (bus.wdata),
            .o_hit   (w_hit),
            .o_data  (w_fwd)
        );

        assign bus.rdata[j] = w_hit ? w_fwd : r_regs[bus.raddr[j]];
        assign bus.rbusy[j] = w_hit ? (bus.issue_valid && bus.issue_rd == bus.raddr[j])
                                    : r_busy[bus.raddr[j]];
    end

    assign bus.busy_count = r_busy_count;
endmodule

// File: tb/tb_scoreboard_regfile.sv
// Randomized bench for scoreboard_regfile against an array-based model,
// plus directed cases with literal expectations.
module tb_scoreboard_regfile;
    import rv32i_types::*;

    localparam int NRD = 2;
    localparam int NWR = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    rv32i_word m_regs [32];
    bit        m_busy [32];
    int        m_count = 0;

    always #5 clk = ~clk;

    scoreboard_regfile_if #(.WIDTH(32), .DEPTH(32), .NRD(NRD), .NWR(NWR)) bus ();

    scoreboard_regfile #(.WIDTH(32), .DEPTH(32), .NRD(NRD), .NWR(NWR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: architectural state after each edge, from the written rules.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 32; k++) begin
                m_regs[k] = '0;
                m_busy[k] = 1'b0;
            end
            m_count = 0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (bus.we[i] && bus.waddr[i] != 0) begin
                    m_regs[bus.waddr[i]] = bus.wdata[i];
                    m_busy[bus.waddr[i]] = 1'b0;
                end
            end
            if (bus.issue_valid && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
            m_count = 0;
            for (int k = 0; k < 32; k++) m_count += int'(m_busy[k]);
        end
    end

    function automatic rv32i_word exp_rdata(input int j);
        rv32i_reg_idx a = bus.raddr[j];
        rv32i_word    v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NWR; i++)
            if (bus.we[i] && bus.waddr[i] == a && a != 0) v = bus.wdata[i];
`endif
        return v;
    endfunction

    function automatic logic exp_rbusy(input int j);
        rv32i_reg_idx a = bus.raddr[j];
        logic         b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NWR; i++)
            if (bus.we[i] && bus.waddr[i] == a && a != 0) b = bus.issue_valid && bus.issue_rd == a;
`endif
        return b;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            for (int j = 0; j < NRD; j++) begin
                check($sformatf("rdata%0d", j), bus.rdata[j], exp_rdata(j));
                check($sformatf("rbusy%0d", j), 32'(bus.rbusy[j]), 32'(exp_rbusy(j)));
            end
            check("busy_count", 32'(bus.busy_count), 32'(m_count));
        end
    end

    task automatic clr();
        bus.we          = '0;
        bus.issue_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        bus.we[p]    = 1'b1;
        bus.waddr[p] = 5'(a);
        bus.wdata[p] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        bus.waddr = '0;
        bus.wdata = '0;
        bus.raddr = '0;
        bus.issue_rd = '0;
        repeat (2) tick();
        check("reset_rdata0", bus.rdata[0], 32'h0);
        check("reset_count", 32'(bus.busy_count), 32'h0);
        mon_en = 1'b1;
        rst = 1'b1;
        tick();

        // Basic write then read, x0 reads zero.
        wr(0, 5, 32'hDEADBEEF);
        tick(); clr();
        bus.raddr[0] = 5'd5; bus.raddr[1] = 5'd0; #1;
        check("x5_read", bus.rdata[0], 32'hDEADBEEF);
        check("x0_read", bus.rdata[1], 32'h0);

        // Same-index collision: port 1 wins; x0 ignores writes.
        wr(0, 7, 32'h11); wr(1, 7, 32'h22);
        tick(); clr();
        wr(0, 0, 32'hFFFF_FFFF);
        tick(); clr();
        bus.raddr[0] = 5'd7; bus.raddr[1] = 5'd0; #1;
        check("x7_port1_wins", bus.rdata[0], 32'h22);
        check("x0_ignores_write", bus.rdata[1], 32'h0);

        // Issue then retire x3.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        tick(); clr();
        bus.raddr[0] = 5'd3; #1;
        check("x3_busy", 32'(bus.rbusy[0]), 32'h1);
        check("count_after_issue", 32'(bus.busy_count), 32'h1);
        wr(1, 3, 32'h33);
        tick(); clr(); #1;
        check("x3_retired", 32'(bus.rbusy[0]), 32'h0);
        check("count_after_retire", 32'(bus.busy_count), 32'h0);
        check("x3_data", bus.rdata[0], 32'h33);

        // Issue and write to x4 in one cycle: issue wins on busy.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd4; wr(0, 4, 32'h55);
        tick(); clr();
        bus.raddr[0] = 5'd4; #1;
        check("x4_data", bus.rdata[0], 32'h55);
        check("x4_still_busy", 32'(bus.rbusy[0]), 32'h1);
        check("count_x4", 32'(bus.busy_count), 32'h1);
        wr(0, 4, 32'h56);
        tick(); clr();

        // Same-cycle read of a register being written.
        wr(0, 9, 32'h01);
        tick(); clr();
        wr(0, 9, 32'hA5); bus.raddr[0] = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
        check("x9_bypass", bus.rdata[0], 32'hA5);
`else
        check("x9_no_bypass", bus.rdata[0], 32'h01);
`endif
        check("x9_rbusy", 32'(bus.rbusy[0]), 32'h0);
        tick(); clr(); #1;
        check("x9_after_edge", bus.rdata[0], 32'hA5);

        // Random traffic, biased toward a few low indices to force collisions.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NWR; i++) begin
                bus.we[i]    = 1'($urandom_range(0, 1));
                bus.waddr[i] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
                bus.wdata[i] = $urandom;
            end
            for (int j = 0; j < NRD; j++)
                bus.raddr[j] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            bus.issue_valid = ($urandom_range(0, 2) == 0);
            bus.issue_rd    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            tick();
        end
        clr();

        // Fill the scoreboard, re-issue a busy entry, then reset mid-cycle.
        wr(0, 5, 32'h1234);
        tick(); clr();
        for (int k = 1; k < 32; k++) begin
            bus.issue_valid = 1'b1; bus.issue_rd = 5'(k);
            tick();
        end
        clr(); #1;
        check("count_full", 32'(bus.busy_count), 32'd31);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
        tick(); clr();
        bus.raddr[0] = 5'd5; bus.raddr[1] = 5'd31; #1;
        check("count_reissue", 32'(bus.busy_count), 32'd31);
        check("x5_before_reset", bus.rdata[0], 32'h1234);
        check("x31_busy", 32'(bus.rbusy[1]), 32'h1);

        @(posedge clk); #2;
        rst = 1'b0; #1;
        check("async_count", 32'(bus.busy_count), 32'h0);
        check("async_rdata0", bus.rdata[0], 32'h0);
        check("async_rbusy1", 32'(bus.rbusy[1]), 32'h0);

        // Writes and issues held during reset must be discarded.
        wr(0, 5, 32'h77); bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
        tick(); tick();
        clr();
        rst = 1'b1; #1;
        check("discard_write", bus.rdata[0], 32'h0);
        check("discard_issue", 32'(bus.busy_count), 32'h0);
        tick();

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
